sha256_msg_schedule: RTL and testbench
======================================

// Module: sha256_msg_schedule
// PURPOSE
//  Message-schedule and round-constant stage directly upstream of the SHA-256 compression round.
//  - Accepts one 512-bit block as 16 words.
//  - Emits one schedule word W[t] and its round constant K[t] per clock, for t=0..63.
//  - These feed the round's w_i/k_i inputs. A 16-word sliding window generates W[16..63] on the fly.
// PARAMETERS
//  n       32   word width in bits (the SHA-256 logic is only defined for 32)
//  m       16   words per block / window depth
//  ROUNDS  64   schedule words emitted per block
// PORTS
//  clk_i      in   1      clock; all state updates on the rising edge
//  rst_i      in   1      synchronous reset, active-high
//  start_i    in   1      start request; sampled only in IDLE
//  hold_i     in   1      stall; in RUN, freezes window, counter and outputs
//  block_i    in   n x m  block words block_i[0:m-1]; block_i[0] = W[0], big-endian word order
//  w_o        out  n      schedule word W[t]
//  k_o        out  n      round constant K[t]
//  round_o    out  6      current t
//  valid_o    out  1      w_o/k_o/round_o valid and advancing this cycle
//  busy_o     out  1      high in RUN
//  done_o     out  1      one-cycle pulse after W[63] is consumed
// BEHAVIOUR
//  - Clock and reset: one clock clk_i; reset rst_i is synchronous and active-high.
//  - Reset (any state, including mid-RUN): state goes to IDLE; window, t, w_o, k_o, round_o,
//    valid_o, busy_o and done_o go to 0. An aborted block is discarded, with no done_o.
//  - FSM states:
//    - IDLE: start_i=1 loads win[0:15] <= block_i[0:15], sets t <= 0 and goes to RUN.
//    - RUN: with hold_i=0, advances one word per cycle. At t=63 with hold_i=0, goes to DONE.
//    - DONE: asserts done_o for one cycle, then goes to IDLE. A start_i seen in DONE is ignored.
//  - Latency: start_i sampled at edge c gives W[0] with valid_o=1 after edge c.
//    - W[t] appears after edge c+t when there are no holds.
//    - The last valid word is followed by the done_o cycle.
//  - Outputs:
//    - w_o = win[0]; k_o = K[t] from the ROM.
//    - valid_o = (state==RUN) & ~hold_i, a combinational AND with hold_i.
//    - w_o/k_o/round_o stay stable while held.
//  - Window update per advancing cycle: win[i] <= win[i+1] for i=0..14; win[15] <= new.
//    - new = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0], all additions mod 2^32
//      with carries discarded.
//    - new equals W[t+16]. It is computed uniformly every cycle; words beyond W[63] are unused.
//  - Sigma functions:
//    - ssig0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
//    - ssig1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
//    - SHR zero-fills; ROTR wraps.
//  - start_i is ignored outside IDLE. start_i together with hold_i in IDLE is still accepted;
//    the hold then applies in RUN.
//  - Counter: t is 6 bits. The 63->0 wrap is never observed because the FSM leaves RUN.
//  - In IDLE/DONE: w_o and k_o hold their last values, round_o=0 and valid_o=0.
//  - Back-to-back blocks: the earliest new start is the IDLE cycle after done_o,
//    which gives 66 cycles per block.
// STRUCTURE
//  - Package sha256_pkg:
//    - localparam logic [31:0] K[0:63], the FIPS 180-4 constants
//    - functions rotr, ssig0, ssig1
//    - typedef enum {IDLE, RUN, DONE} sched_state_t
//    - typedef logic [31:0] word_t
//  - Sub-module sha256_k_rom: combinational 6-bit address to 32-bit constant.
//    It is shared with any future unrolled round.
//  - The rest is one always_ff for state, window and counter, plus combinational output logic.
// TESTING
//  1. Reset mid-RUN at t=20 -> next cycle valid_o=0, busy_o=0, round_o=0, w_o=0;
//     done_o never pulses; a later start behaves as a fresh block.
//  2. "abc" padded block (block_i[0]=32'h61626380, block_i[15]=32'h00000018, others 0):
//     - W[0]=61626380, W[15]=00000018, W[16]=61626380, W[17]=000F0000
//     - K[0]=428A2F98, K[63]=C67178F2
//     - done_o exactly 1 cycle after round_o=63
//  3. hold_i=1 for 5 cycles at t=10 -> w_o/k_o/round_o frozen at t=10, valid_o=0;
//     the W sequence resumes unchanged; total cycles to done_o = 65+5.
//  4. start_i pulsed at t=30 and in the DONE cycle -> both ignored; exactly one done_o per block.
//  5. Two blocks back-to-back, start on the first IDLE cycle after done_o ->
//     second W[0] appears 66 cycles after the first; all 128 words match a C reference model.
//  6. Random blocks x1000, with hash obtained via computation chained downstream ->
//     digest matches the software SHA-256 model.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants and message-schedule sigma functions.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WIN_DEPTH = 16;
  localparam int unsigned ROUNDS    = 64;
  localparam int unsigned ROUND_W   = 6;
  localparam int unsigned BLOCK_W   = WORD_W * WIN_DEPTH;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // FIPS 180-4 round constants K[0..63]
  localparam word_t K [0:ROUNDS-1] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned s);
    return (x >> s) | (x << (WORD_W - s));
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant ROM: 6-bit round index to K[t].
import sha256_pkg::*;

module sha256_k_rom (
  input  logic [5:0]  addr_i,
  output logic [31:0] k_o
);

  assign k_o = K[addr_i];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: streams W[t] and K[t] for t=0..63 from one 512-bit block.
// block_i word 0 (W[0]) sits in the most significant 32 bits.
import sha256_pkg::*;

module sha256_msg_schedule (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         hold_i,
  input  logic [511:0] block_i,
  output logic [31:0]  w_o,
  output logic [31:0]  k_o,
  output logic [5:0]   round_o,
  output logic         valid_o,
  output logic         busy_o,
  output logic         done_o
);

  sched_state_t        state_q, state_d;
  word_t               win_q [WIN_DEPTH];
  word_t               win_d [WIN_DEPTH];
  logic [ROUND_W-1:0]  t_q, t_d;
  word_t               k_q, k_d;
  logic [ROUND_W-1:0]  rom_addr;
  word_t               rom_k;
  word_t               new_word;
  logic                last_round;

  sha256_k_rom u_k_rom (
    .addr_i (rom_addr),
    .k_o    (rom_k)
  );

  // Look one round ahead so k_q lines up with the word shifted into win_q[0].
  assign rom_addr   = (state_q == RUN) ? ROUND_W'(t_q + 1'b1) : '0;
  assign last_round = (t_q == ROUND_W'(ROUNDS - 1));
  assign new_word   = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    t_d     = t_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          t_d     = '0;
          k_d     = rom_k;
          for (int unsigned i = 0; i < WIN_DEPTH; i++) begin
            win_d[i] = block_i[(WIN_DEPTH - 1 - i) * WORD_W +: WORD_W];
          end
        end
      end
      RUN: begin
        if (!hold_i) begin
          // The final word is left on w_o/k_o, so the window does not shift past W[63].
          if (last_round) begin
            state_d = DONE;
            t_d     = '0;
          end else begin
            t_d = ROUND_W'(t_q + 1'b1);
            k_d = rom_k;
            for (int unsigned i = 0; i < WIN_DEPTH - 1; i++) begin
              win_d[i] = win_q[i + 1];
            end
            win_d[WIN_DEPTH - 1] = new_word;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      t_q     <= '0;
      k_q     <= '0;
      for (int unsigned i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      k_q     <= k_d;
      for (int unsigned i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign w_o     = win_q[0];
  assign k_o     = k_q;
  assign round_o = t_q;
  assign valid_o = (state_q == RUN) & ~hold_i;
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: schedule words, constants, holds, aborts and a chained digest.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         hold;
  logic [511:0] block;
  logic [31:0]  w_o, k_o;
  logic [5:0]   round_o;
  logic         valid_o, busy_o, done_o;

  int           total = 0;
  int           passed = 0;
  int           cycle = 0;
  int           done_cnt = 0;
  int           w0_cycle, done_cycle, first_w0, d0;
  logic [31:0]  wexp [64];
  logic [31:0]  wrec [64];
  logic [31:0]  krec [64];
  logic [511:0] abc, rblk;

  sha256_msg_schedule dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .hold_i  (hold),
    .block_i (block),
    .w_o     (w_o),
    .k_o     (k_o),
    .round_o (round_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) if (done_o) done_cnt <= done_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule straight from the FIPS recurrence
  task automatic model_w(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) wexp[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      wexp[i] = (ror(wexp[i-2], 17) ^ ror(wexp[i-2], 19) ^ (wexp[i-2] >> 10)) + wexp[i-7]
              + (ror(wexp[i-15], 7) ^ ror(wexp[i-15], 18) ^ (wexp[i-15] >> 3)) + wexp[i-16];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // Starts a block and follows it to the done_o cycle, checking every word.
  task automatic run_block(input logic [511:0] blk, input int hold_at, input int hold_len,
                           input int start_at);
    model_w(blk);
    block = blk;
    start = 1'b1;
    step();
    start = 1'b0;
    w0_cycle = cycle;
    for (int t = 0; t < 64; t++) begin
      chk($sformatf("round[%0d]", t), 32'(round_o), 32'(t));
      chk($sformatf("w[%0d]", t), w_o, wexp[t]);
      chk($sformatf("busy[%0d]", t), 32'(busy_o), 32'd1);
      wrec[t] = w_o;
      krec[t] = k_o;
      if (t == hold_at) begin
        hold = 1'b1;
        #1;
        chk("hold_valid", 32'(valid_o), 32'd0);
        for (int h = 0; h < hold_len; h++) begin
          step();
          chk($sformatf("hold_round[%0d]", h), 32'(round_o), 32'(t));
          chk($sformatf("hold_w[%0d]", h), w_o, wexp[t]);
          chk($sformatf("hold_valid[%0d]", h), 32'(valid_o), 32'd0);
        end
        hold = 1'b0;
        #1;
      end
      chk($sformatf("valid[%0d]", t), 32'(valid_o), 32'd1);
      if (t == start_at) start = 1'b1;
      step();
      start = 1'b0;
    end
    done_cycle = cycle;
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("done_valid", 32'(valid_o), 32'd0);
    chk("done_round", 32'(round_o), 32'd0);
    chk("done_busy", 32'(busy_o), 32'd0);
    chk("done_w_held", w_o, wexp[63]);
  endtask

  // Compression round driven by the recorded W/K stream
  task automatic digest_chk(input logic [31:0] exp [8]);
    logic [31:0] h [8];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    {a, b, c, d, e, f, g, hh} = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + krec[t] + wrec[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    for (int i = 0; i < 8; i++) chk($sformatf("digest[%0d]", i), h[i], exp[i]);
  endtask

  initial begin
    logic [31:0] abc_digest [8];
    abc_digest = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                   32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    abc = '0;
    abc[511 -: 32] = 32'h61626380;
    abc[31:0]      = 32'h00000018;

    rst = 1'b1; start = 1'b0; hold = 1'b0; block = '0;
    repeat (3) step();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_round", 32'(round_o), 32'd0);
    chk("rst_w", w_o, 32'd0);
    chk("rst_k", k_o, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy_o), 32'd0);

    // "abc" block and its chained digest
    run_block(abc, -1, 0, -1);
    chk("abc_w0", wrec[0], 32'h61626380);
    chk("abc_w15", wrec[15], 32'h00000018);
    chk("abc_w16", wrec[16], 32'h61626380);
    chk("abc_w17", wrec[17], 32'h000f0000);
    chk("abc_k0", krec[0], 32'h428a2f98);
    chk("abc_k1", krec[1], 32'h71374491);
    chk("abc_k63", krec[63], 32'hc67178f2);
    chk("abc_k_held", k_o, 32'hc67178f2);
    chk("abc_done_lat", 32'(done_cycle - w0_cycle), 32'd64);
    digest_chk(abc_digest);
    step();
    chk("after_done", 32'(done_o), 32'd0);
    chk("after_busy", 32'(busy_o), 32'd0);

    // Five-cycle hold at t=10
    run_block(abc, 10, 5, -1);
    chk("hold_total", 32'(done_cycle - w0_cycle + 1), 32'd70);
    digest_chk(abc_digest);
    step();

    // start_i mid-RUN and in DONE is ignored
    d0 = done_cnt;
    run_block(rand_block(), -1, 0, 30);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done_start_ign0", 32'(busy_o), 32'd0);
    step();
    chk("done_start_ign1", 32'(busy_o), 32'd0);
    chk("one_done", 32'(done_cnt - d0), 32'd1);

    // Reset mid-RUN at t=20
    d0 = done_cnt;
    rblk = rand_block();
    block = rblk;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("abort_round20", 32'(round_o), 32'd20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_round", 32'(round_o), 32'd0);
    chk("abort_w", w_o, 32'd0);
    chk("abort_k", k_o, 32'd0);
    repeat (70) step();
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    run_block(rblk, -1, 0, -1);
    step();

    // Back-to-back blocks
    run_block(rand_block(), -1, 0, -1);
    first_w0 = w0_cycle;
    step();
    run_block(rand_block(), -1, 0, -1);
    chk("b2b_spacing", 32'(w0_cycle - first_w0), 32'd66);
    step();

    // Random blocks with scattered holds
    for (int r = 0; r < 10; r++) begin
      run_block(rand_block(), $urandom_range(0, 63), $urandom_range(0, 3), -1);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
